prm_edge_scan: RTL and testbench

PRM_EDGE_SCAN -- requirements
Module: prm_edge_scan

---
 rtl/prm_edge_scan.sv | 168 ++++++++++++++++
 tb/tb_prm_edge_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/prm_edge_scan.sv
// prm_edge_scan: walks the straight edge cfg_a -> cfg_b in 2^LOG2_STEPS intervals.
// It presents each sample code to an external combinational collision checker.
// Latency: start in cycle T gives samples in T+1..T+STEPS+1 and done in T+STEPS+2.
//   A collision or abort ends the scan early.
// Backpressure: none. The checker must answer chk_mask in the same cycle that
//   chk_valid is high. start is accepted only while idle.
// Ports:
//   CLK, RST_N (async active-low)
//   start/abort  - launch and cancel controls
//   cfg_a/cfg_b  - edge end-point codes (JOINTS unsigned fields of JW bits)
//   chk_code/chk_valid/chk_mask - sample handshake with the collision checker
//   busy/done/edge_free/hit_step - status and result of the last completed scan
module prm_edge_scan #(
    parameter int JOINTS     = 3,
    parameter int JW         = 5,
    parameter int LOG2_STEPS = 4,
    localparam int CW        = JOINTS * JW,
    localparam int KW        = LOG2_STEPS + 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] cfg_a,
    input  logic [CW-1:0] cfg_b,
    output logic [CW-1:0] chk_code,
    output logic          chk_valid,
    input  logic          chk_mask,
    output logic          busy,
    output logic          done,
    output logic          edge_free,
    output logic [KW-1:0] hit_step
);
    localparam int AW    = JW + LOG2_STEPS + 1;
    localparam int STEPS = 1 << LOG2_STEPS;
    localparam logic [KW-1:0] K_LAST = KW'(STEPS);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]        a_q, a_d;
    logic signed [JW:0]   d_q   [JOINTS];
    logic signed [JW:0]   d_d   [JOINTS];
    // acc_q[j] holds (b_j - a_j) * (k+1): the numerator of the sample after the
    // one currently on chk_code, so the next code can be registered directly.
    logic signed [AW-1:0] acc_q [JOINTS];
    logic signed [AW-1:0] acc_d [JOINTS];
    logic [CW-1:0]        chk_code_q, chk_code_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 edge_free_q, edge_free_d;
    logic [KW-1:0]        hit_step_q, hit_step_d;

    logic                 launch;
    logic                 scan_live;
    logic                 last_k;

    assign launch    = (state_q == IDLE) && start;
    assign scan_live = (state_q == SCAN) && !abort;
    assign last_k    = (k_q == K_LAST);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks a collision in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = SCAN;
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (chk_mask || last_k) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy      = 1'b0;
        chk_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            SCAN: begin
                busy      = 1'b1;
                chk_valid = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        a_d         = a_q;
        d_d         = d_q;
        acc_d       = acc_q;
        chk_code_d  = chk_code_q;
        k_d         = k_q;
        edge_free_d = edge_free_q;
        hit_step_d  = hit_step_q;

        if (launch) begin
            a_d        = cfg_a;
            chk_code_d = cfg_a;
            k_d        = '0;
            for (int j = 0; j < JOINTS; j++) begin
                d_d[j]   = $signed({1'b0, cfg_b[j*JW +: JW]}) - $signed({1'b0, cfg_a[j*JW +: JW]});
                acc_d[j] = {{LOG2_STEPS{d_d[j][JW]}}, d_d[j]};
            end
        end else if (scan_live) begin
            if (chk_mask) begin
                edge_free_d = 1'b0;
                hit_step_d  = k_q;
            end else if (last_k) begin
                edge_free_d = 1'b1;
                hit_step_d  = '0;
            end else begin
                k_d = k_q + KW'(1);
                for (int j = 0; j < JOINTS; j++) begin
                    // Arithmetic shift floors toward minus infinity; the sum always
                    // lands inside [0, 2^JW), so keeping the low JW bits is exact.
                    chk_code_d[j*JW +: JW] = a_q[j*JW +: JW] + JW'(acc_q[j] >>> LOG2_STEPS);
                    acc_d[j] = acc_q[j] + {{LOG2_STEPS{d_q[j][JW]}}, d_q[j]};
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q         <= '0;
            chk_code_q  <= '0;
            k_q         <= '0;
            edge_free_q <= 1'b0;
            hit_step_q  <= '0;
            for (int j = 0; j < JOINTS; j++) begin
                d_q[j]   <= '0;
                acc_q[j] <= '0;
            end
        end else begin
            a_q         <= a_d;
            chk_code_q  <= chk_code_d;
            k_q         <= k_d;
            edge_free_q <= edge_free_d;
            hit_step_q  <= hit_step_d;
            for (int j = 0; j < JOINTS; j++) begin
                d_q[j]   <= d_d[j];
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign chk_code  = chk_code_q;
    assign edge_free = edge_free_q;
    assign hit_step  = hit_step_q;

endmodule

// File: tb/tb_prm_edge_scan.sv
// Directed bench for prm_edge_scan with hand-derived expected sample codes.
module tb_prm_edge_scan;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start, abort, chk_mask;
    logic [14:0] cfg_a, cfg_b;
    logic [14:0] chk_code;
    logic        chk_valid, busy, done, edge_free;
    logic [4:0]  hit_step;

    int n_cmp = 0;
    int n_err = 0;
    logic       prev_free;
    logic [4:0] prev_hit;
    int f0_tbl [17] = '{31, 29, 27, 25, 23, 21, 19, 17, 15, 13, 11, 9, 7, 5, 3, 1, 0};

    prm_edge_scan dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .abort     (abort),
        .cfg_a     (cfg_a),
        .cfg_b     (cfg_b),
        .chk_code  (chk_code),
        .chk_valid (chk_valid),
        .chk_mask  (chk_mask),
        .busy      (busy),
        .done      (done),
        .edge_free (edge_free),
        .hit_step  (hit_step)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent reference: a_j + floor((b_j - a_j) * k / 16) per field.
    function automatic logic [14:0] exp_code(input logic [14:0] a, input logic [14:0] b, input int k);
        logic [14:0] r;
        r = '0;
        for (int j = 0; j < 3; j++) begin
            int ai, bi, n, q;
            ai = int'(a[j*5 +: 5]);
            bi = int'(b[j*5 +: 5]);
            n  = (bi - ai) * k;
            q  = n / 16;
            if (n < 0 && (n % 16) != 0) q = q - 1;
            r[j*5 +: 5] = 5'(ai + q);
        end
        return r;
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Runs one scan from IDLE (called at posedge+1). hit_k/abort_k/rst_k < 0 disable.
    task automatic run_scan(input logic [14:0] a, input logic [14:0] b, input int hit_k,
                            input int abort_k, input int rst_k, input bit use_tbl,
                            input bit abort_at_start, input string tag);
        int last;
        bit aborted;
        logic [14:0] last_code;
        cfg_a = a;
        cfg_b = b;
        start = 1'b1;
        abort = abort_at_start;
        step();
        start = 1'b0;
        abort = 1'b0;
        cfg_a = ~a;              // late edits must not leak into the scan
        cfg_b = ~b;
        last = 16;
        if (hit_k >= 0 && hit_k < last) last = hit_k;
        aborted = (abort_k >= 0 && abort_k <= last);
        if (aborted) last = abort_k;
        for (int k = 0; k <= last; k++) begin
            check({tag, ":valid"}, 32'(chk_valid), 32'd1);
            check({tag, ":busy"}, 32'(busy), 32'd1);
            check({tag, ":code"}, 32'(chk_code), 32'(exp_code(a, b, k)));
            if (use_tbl) check({tag, ":f0"}, 32'(chk_code[4:0]), 32'(f0_tbl[k]));
            if (k == rst_k) begin
                RST_N = 1'b0;
                #1;
                check({tag, ":rst_busy"}, 32'(busy), 32'd0);
                check({tag, ":rst_valid"}, 32'(chk_valid), 32'd0);
                check({tag, ":rst_done"}, 32'(done), 32'd0);
                check({tag, ":rst_code"}, 32'(chk_code), 32'd0);
                check({tag, ":rst_free"}, 32'(edge_free), 32'd0);
                check({tag, ":rst_hit"}, 32'(hit_step), 32'd0);
                step();
                RST_N = 1'b1;
                prev_free = 1'b0;
                prev_hit  = '0;
                for (int c = 0; c < 3; c++) begin
                    step();
                    check({tag, ":post_rst_done"}, 32'(done), 32'd0);
                    check({tag, ":post_rst_busy"}, 32'(busy), 32'd0);
                end
                return;
            end
            chk_mask = (k == hit_k);
            abort    = (k == abort_k);
            start    = 1'b1;     // must be ignored mid-scan
            step();
            chk_mask = 1'b0;
            abort    = 1'b0;
            start    = 1'b0;
        end
        last_code = exp_code(a, b, last);
        check({tag, ":end_valid"}, 32'(chk_valid), 32'd0);
        check({tag, ":end_busy"}, 32'(busy), 32'd0);
        check({tag, ":end_hold"}, 32'(chk_code), 32'(last_code));
        if (aborted) begin
            check({tag, ":abort_done"}, 32'(done), 32'd0);
        end else begin
            check({tag, ":done"}, 32'(done), 32'd1);
            prev_free = (hit_k < 0 || hit_k > 16);
            prev_hit  = prev_free ? 5'd0 : 5'(hit_k);
        end
        check({tag, ":free"}, 32'(edge_free), 32'(prev_free));
        check({tag, ":hit"}, 32'(hit_step), 32'(prev_hit));
        step();
        check({tag, ":idle_done"}, 32'(done), 32'd0);
        check({tag, ":idle_busy"}, 32'(busy), 32'd0);
        check({tag, ":idle_hold"}, 32'(chk_code), 32'(last_code));
    endtask

    initial begin
        RST_N    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        chk_mask = 1'b0;
        cfg_a    = 15'h1111;
        cfg_b    = 15'h2222;
        prev_free = 1'b0;
        prev_hit  = '0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_valid", 32'(chk_valid), 32'd0);
        check("reset_code", 32'(chk_code), 32'd0);
        check("reset_free", 32'(edge_free), 32'd0);
        check("reset_hit", 32'(hit_step), 32'd0);
        step();
        step();
        RST_N = 1'b1;

        run_scan(15'h0000, 15'h7FFF, -1, -1, -1, 1'b0, 1'b0, "full");
        check("full_k8_code_model", 32'(exp_code(15'h0000, 15'h7FFF, 8)), 32'h3DEF);
        run_scan(15'h0421, 15'h7C1F, 5, -1, -1, 1'b0, 1'b0, "hit5");
        abort = 1'b1;            // abort while idle has no effect
        step();
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        run_scan(15'h7C00, 15'h03FF, -1, 3, -1, 1'b0, 1'b0, "abort3");
        run_scan(15'h001F, 15'h0000, -1, -1, -1, 1'b1, 1'b0, "floor");
        run_scan(15'h3A5C, 15'h05E3, -1, -1, 10, 1'b0, 1'b0, "rst10");
        run_scan(15'h2B17, 15'h4C09, 16, -1, -1, 1'b0, 1'b0, "hit16");
        run_scan(15'h1234, 15'h1234, -1, -1, -1, 1'b0, 1'b1, "same");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
